// File: rtl/multu_hilo_unit.sv
// Multi-cycle shift-add unsigned multiplier with HI/LO result registers.
// Takes WIDTH RUN cycles per MULTU; busy stalls the front of the pipeline meanwhile.
module multu_hilo_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [2*WIDTH:0] prod_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   upper_d;
    logic [2*WIDTH:0] prod_d;

    // One shift-add step; the carry out of the add lands in prod[2W] before the shift.
    always_comb begin
        upper_d = prod_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod_d  = {upper_d, prod_q[WIDTH-1:0]} >> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mcand_q  <= src_a;
                        mplier_q <= src_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    prod_q   <= prod_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Final step commits its own result so RUN lasts exactly WIDTH cycles.
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench for multu_hilo_unit against a 64-bit arithmetic reference.
module tb_multu_hilo_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference HI/LO: last committed product
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    multu_hilo_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Called at the negedge right after the accepting edge; returns at the negedge of the done cycle.
    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b,
                               input string name, input int restart_at);
        logic [2*W-1:0] p;
        int busy_cnt;
        bit hold_ok;
        bit seen;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        busy_cnt = 0;
        hold_ok = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            if (i == restart_at) begin
                start = 1'b1;
                src_a = 9;
                src_b = 9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: done=%0b after 100 cycles, required 1", name, done);
        end
        n_checks++;
        if (busy_cnt != int'(W)) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required %0d", name, busy_cnt, W);
        end
        n_checks++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL %s hilo_hold: hi/lo changed during RUN, required %h/%h", name, m_hi, m_lo);
        end
        n_checks++;
        if ({hi, lo} !== p) begin
            n_fail++;
            $display("FAIL %s product: got hi=%h lo=%h, required hi=%h lo=%h",
                     name, hi, lo, p[2*W-1:W], p[W-1:0]);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_in_done: got %b, required 0", name, busy);
        end
        m_hi = p[2*W-1:W];
        m_lo = p[W-1:0];
    endtask

    task automatic check_done_drop(input string name);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s after_done: got done=%b busy=%b hi=%h lo=%h, required 0 0 %h %h",
                     name, done, busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        src_a = '0;
        src_b = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, required 0 0 0 0",
                     busy, done, hi, lo);
        end
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_basic();
        issue(32'd6, 32'd7);
        wait_result(32'd6, 32'd7, "mul_6x7", -1);
        check_done_drop("mul_6x7");
    endtask

    task automatic test_boundaries();
        issue('1, '1);
        wait_result('1, '1, "mul_max", -1);
        check_done_drop("mul_max");
        issue(32'h8000_0000, 32'd2);
        wait_result(32'h8000_0000, 32'd2, "mul_carry_hi", -1);
        check_done_drop("mul_carry_hi");
        issue(32'd0, 32'd1234);
        wait_result(32'd0, 32'd1234, "mul_zero", -1);
        check_done_drop("mul_zero");
    endtask

    task automatic test_start_in_run();
        issue(32'd3, 32'd5);
        wait_result(32'd3, 32'd5, "start_in_run", 10);
        check_done_drop("start_in_run");
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        issue(32'd3, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_hi = '0;
        m_lo = '0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b hi=%h lo=%h, required 0 0 0 0",
                     busy, done, hi, lo);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_checks++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles, required 0", done_seen);
        end
    endtask

    task automatic test_back_to_back();
        issue(32'd2, 32'd3);
        wait_result(32'd2, 32'd3, "b2b_first", -1);
        start = 1'b1;
        src_a = 32'd4;
        src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || lo !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b lo=%h, required 1 0 00000006",
                     busy, done, lo);
        end
        wait_result(32'd4, 32'd5, "b2b_second", -1);
        check_done_drop("b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int k = 0; k < 8; k++) begin
            a = $urandom;
            b = $urandom;
            if (k == 0) b[W-1] = 1'b1;
            if (k == 1) a = a >> $urandom_range(0, W - 1);
            issue(a, b);
            wait_result(a, b, "mul_random", -1);
            check_done_drop("mul_random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
